// File: rtl/ps2_kbd_tx_pkg.sv
// Shared definitions for the PS/2 keyboard-side transmitter: FSM state
// encoding, frame geometry and the frame builder used when a byte is loaded.
package ps2_kbd_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_BIT  = 2'd2,
      ST_GAP  = 2'd3
   } tx_state_t;

   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_STOP_IDX   = 10;

   typedef logic [PS2_FRAME_BITS-1:0] ps2_frame_t;

   // Frame in transmit order from bit 0: start 0, D0..D7, odd parity, stop 1.
   function automatic ps2_frame_t build_frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Valid/ready byte stream feeding scancodes into the PS/2 transmitter.
interface ps2_kbd_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_kbd_tx_fifo.sv
// Small synchronous FIFO holding queued scancodes. The head is peeked while a
// frame is in flight and only popped once the stop bit has gone out.
module ps2_kbd_tx_fifo #(
   parameter int FIFO_AW = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [7:0]         push_data,
   input  logic               pop,
   output logic [7:0]         head,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   level
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (level == (FIFO_AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array: written on accepted push only.
   // NOTE: the data array carries no reset; flushing is done by clearing the pointers and level.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy; push and pop in one cycle leave the level unchanged.
   // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (FIFO_AW+1)'(1);
            2'b01:   level <= level - (FIFO_AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: drains the scancode FIFO and serialises each
// byte as an 11-bit frame, generating both ps2_clk and ps2_dat from registers.
module ps2_kbd_tx
   import ps2_kbd_tx_pkg::*;
#(
   parameter int HALF_PER = 500,
   parameter int GAP_CYC  = 2000,
   parameter int FIFO_AW  = 3
) (
   input  logic             clk,
   input  logic             reset,
   ps2_kbd_tx_if.slave      tx,
   input  logic             inhibit,
   output logic             ps2_clk,
   output logic             ps2_dat,
   output logic             busy,
   output logic [FIFO_AW:0] fifo_level
);

   localparam int CW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [3:0] STOP_IDX = 4'(PS2_STOP_IDX);

   tx_state_t  state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic [3:0]    idx, idx_n;
   logic          phase_lo, phase_lo_n;
   ps2_frame_t    shreg, shreg_n;
   logic          clk_n, dat_n;
   logic          pop;
   logic [7:0]    head;
   logic          full;
   logic          empty;

   ps2_kbd_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx.tx_valid),
      .push_data (tx.tx_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   assign tx.tx_ready = !full;
   assign busy        = (state != ST_IDLE);

   // Register stage for the FSM, timing counters, shift register and both PS/2 lines.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         gap_cnt  <= '0;
         idx      <= '0;
         phase_lo <= 1'b0;
         shreg    <= '1;
         ps2_clk  <= 1'b1;
         ps2_dat  <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         gap_cnt  <= gap_cnt_n;
         idx      <= idx_n;
         phase_lo <= phase_lo_n;
         shreg    <= shreg_n;
         ps2_clk  <= clk_n;
         ps2_dat  <= dat_n;
      end
   end

   // Next-state logic: start, per-half-period clocking, bit advance, abort and gap.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      gap_cnt_n  = gap_cnt;
      idx_n      = idx;
      phase_lo_n = phase_lo;
      shreg_n    = shreg;
      clk_n      = ps2_clk;
      dat_n      = ps2_dat;
      pop        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!empty && !inhibit) state_n = ST_LOAD;
         end

         ST_LOAD: begin
            shreg_n    = build_frame(head);
            dat_n      = 1'b0;
            clk_n      = 1'b1;
            cnt_n      = CW'(HALF_PER - 1);
            idx_n      = '0;
            phase_lo_n = 1'b0;
            state_n    = ST_BIT;
         end

         ST_BIT: begin
            if (inhibit && !(idx == STOP_IDX && phase_lo)) begin
               // Host pulled the clock: drop the frame, keep the byte for a retry.
               clk_n     = 1'b1;
               dat_n     = 1'b1;
               gap_cnt_n = GW'(GAP_CYC - 1);
               state_n   = ST_GAP;
            end else if (cnt != '0) begin
               cnt_n = cnt - CW'(1);
            end else if (!phase_lo) begin
               phase_lo_n = 1'b1;
               clk_n      = 1'b0;
               cnt_n      = CW'(HALF_PER - 1);
            end else if (idx == STOP_IDX) begin
               pop       = 1'b1;
               clk_n     = 1'b1;
               dat_n     = 1'b1;
               gap_cnt_n = GW'(GAP_CYC - 1);
               state_n   = ST_GAP;
            end else begin
               idx_n      = idx + 4'd1;
               shreg_n    = {1'b1, shreg[PS2_FRAME_BITS-1:1]};
               dat_n      = shreg[1];
               clk_n      = 1'b1;
               phase_lo_n = 1'b0;
               cnt_n      = CW'(HALF_PER - 1);
            end
         end

         ST_GAP: begin
            if (gap_cnt == '0) state_n = ST_IDLE;
            else               gap_cnt_n = gap_cnt - GW'(1);
         end

         default: state_n = ST_IDLE;
      endcase
   end

endmodule
